// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: arbitrates icache/dcache line requests onto the beat-level banked memory bus and reassembles read bursts into lines.
module bmem_line_adapter #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int BURST_LEN  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ADDR_WIDTH-1:0]           ic_addr,
   input  logic                            ic_read,
   output logic [BUS_WIDTH*BURST_LEN-1:0]  ic_rdata,
   output logic                            ic_resp,
   input  logic [ADDR_WIDTH-1:0]           dc_addr,
   input  logic                            dc_read,
   input  logic                            dc_write,
   input  logic [BUS_WIDTH*BURST_LEN-1:0]  dc_wdata,
   output logic [BUS_WIDTH*BURST_LEN-1:0]  dc_rdata,
   output logic                            dc_resp,
   output logic [ADDR_WIDTH-1:0]           bmem_addr,
   output logic                            bmem_read,
   output logic                            bmem_write,
   output logic [BUS_WIDTH-1:0]            bmem_wdata,
   input  logic                            bmem_ready,
   input  logic [ADDR_WIDTH-1:0]           bmem_raddr,
   input  logic [BUS_WIDTH-1:0]            bmem_rdata,
   input  logic                            bmem_rvalid,
   output logic                            err
);
   localparam int LINE_W = BUS_WIDTH*BURST_LEN;
   localparam int OFF    = $clog2(LINE_W/8);
   localparam int CW     = $clog2(BURST_LEN);
   localparam int TW     = ADDR_WIDTH-OFF;

   typedef enum logic [1:0] {FREE, ISSUED, WAIT_DATA, RESP} port_e;
   typedef enum logic [1:0] {IDLE, REQ, WBURST} iss_e;

   port_e                 ic_st_q, dc_st_q;
   iss_e                  st_q;
   logic [TW-1:0]         ic_tag_q, dc_tag_q;
   logic                  prio_dc_q, cur_wr_q;
   logic [CW-1:0]         k_q;
   logic [ADDR_WIDTH-1:0] bmem_addr_q;
   logic                  bmem_read_q, bmem_write_q;
   logic [BUS_WIDTH-1:0]  bmem_wdata_q;

   logic                  col_act_q, col_dc_q, err_q;
   logic [CW-1:0]         col_cnt_q;
   logic [ADDR_WIDTH-1:0] col_addr_q;
   logic [LINE_W-BUS_WIDTH-1:0] col_line_q;
   logic [LINE_W-1:0]     ic_rdata_q, dc_rdata_q;

   logic [TW-1:0] ic_tag, dc_tag, r_tag;
   logic ic_ok, dc_ok, gnt_ic, gnt_dc, req_acc, wr_last, beat_ok, fin, m_ic, m_dc;
   logic unused_ok;

   assign ic_tag = ic_addr[ADDR_WIDTH-1:OFF];
   assign dc_tag = dc_addr[ADDR_WIDTH-1:OFF];
   assign r_tag  = bmem_raddr[ADDR_WIDTH-1:OFF];
   assign unused_ok = ^{ic_addr[OFF-1:0], dc_addr[OFF-1:0]};

   // A read may not chase a line the other port is still waiting on, so a returning burst matches at most one port.
   assign ic_ok  = ic_read && ic_st_q == FREE && !(dc_st_q == WAIT_DATA && dc_tag_q == ic_tag);
   assign dc_ok  = (dc_read || dc_write) && dc_st_q == FREE &&
                   !(dc_read && ic_st_q == WAIT_DATA && ic_tag_q == dc_tag);
   assign gnt_dc = st_q == IDLE && dc_ok && (prio_dc_q || !ic_ok);
   assign gnt_ic = st_q == IDLE && ic_ok && !gnt_dc;
   assign req_acc = st_q == REQ && bmem_ready;
   assign wr_last = st_q == WBURST && bmem_ready && k_q == CW'(BURST_LEN-1);

   assign m_ic    = ic_st_q == WAIT_DATA && ic_tag_q == r_tag;
   assign m_dc    = dc_st_q == WAIT_DATA && dc_tag_q == r_tag;
   assign beat_ok = col_act_q && bmem_rvalid && bmem_raddr == col_addr_q;
   assign fin     = beat_ok && col_cnt_q == CW'(BURST_LEN-1);

   assign bmem_addr  = bmem_addr_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_write = bmem_write_q;
   assign bmem_wdata = bmem_wdata_q;
   assign ic_resp    = ic_st_q == RESP;
   assign dc_resp    = dc_st_q == RESP;
   assign ic_rdata   = ic_rdata_q;
   assign dc_rdata   = dc_rdata_q;
   assign err        = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= IDLE;
         ic_st_q      <= FREE;
         dc_st_q      <= FREE;
         ic_tag_q     <= '0;
         dc_tag_q     <= '0;
         prio_dc_q    <= 1'b1;
         cur_wr_q     <= 1'b0;
         k_q          <= '0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
      end else begin
         case (st_q)
            IDLE: if (gnt_ic || gnt_dc) begin
               st_q         <= REQ;
               cur_wr_q     <= gnt_dc && dc_write;
               prio_dc_q    <= gnt_ic;
               bmem_addr_q  <= {gnt_dc ? dc_tag : ic_tag, {OFF{1'b0}}};
               bmem_read_q  <= gnt_ic || dc_read;
               bmem_write_q <= gnt_dc && dc_write;
               bmem_wdata_q <= (gnt_dc && dc_write) ? dc_wdata[BUS_WIDTH-1:0] : '0;
            end
            REQ: if (bmem_ready) begin
               st_q         <= cur_wr_q ? WBURST : IDLE;
               k_q          <= CW'(1);
               bmem_read_q  <= 1'b0;
               bmem_write_q <= 1'b0;
               bmem_wdata_q <= cur_wr_q ? dc_wdata[BUS_WIDTH +: BUS_WIDTH] : '0;
            end
            WBURST: if (bmem_ready) begin
               st_q         <= wr_last ? IDLE : WBURST;
               k_q          <= k_q + 1'b1;
               bmem_wdata_q <= wr_last ? '0 : dc_wdata[BUS_WIDTH*(int'(k_q)+1) +: BUS_WIDTH];
            end
            default: st_q <= IDLE;
         endcase
         if (gnt_ic) begin
            ic_st_q  <= ISSUED;
            ic_tag_q <= ic_tag;
         end else if (ic_st_q == ISSUED && req_acc) ic_st_q <= WAIT_DATA;
         else if (ic_st_q == WAIT_DATA && fin && !col_dc_q) ic_st_q <= RESP;
         else if (ic_st_q == RESP) ic_st_q <= FREE;
         if (gnt_dc) begin
            dc_st_q  <= ISSUED;
            dc_tag_q <= dc_tag;
         end else if (dc_st_q == ISSUED && req_acc && !cur_wr_q) dc_st_q <= WAIT_DATA;
         else if (dc_st_q == ISSUED && wr_last) dc_st_q <= RESP;
         else if (dc_st_q == WAIT_DATA && fin && col_dc_q) dc_st_q <= RESP;
         else if (dc_st_q == RESP) dc_st_q <= FREE;
      end
   end

   // Response collector: independent of issue; a bad burst is dropped and the collector rearms on the next rvalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_act_q  <= 1'b0;
         col_dc_q   <= 1'b0;
         col_cnt_q  <= '0;
         col_addr_q <= '0;
         col_line_q <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
         err_q      <= 1'b0;
      end else if (!col_act_q) begin
         if (bmem_rvalid && (m_ic || m_dc)) begin
            col_act_q  <= 1'b1;
            col_cnt_q  <= CW'(1);
            col_addr_q <= bmem_raddr;
            col_dc_q   <= m_dc;
            col_line_q[BUS_WIDTH-1:0] <= bmem_rdata;
         end else if (bmem_rvalid) err_q <= 1'b1;
      end else if (!beat_ok) begin
         err_q     <= 1'b1;
         col_act_q <= 1'b0;
      end else if (fin) begin
         col_act_q <= 1'b0;
         if (col_dc_q) dc_rdata_q <= {bmem_rdata, col_line_q};
         else ic_rdata_q <= {bmem_rdata, col_line_q};
      end else begin
         col_line_q[BUS_WIDTH*col_cnt_q +: BUS_WIDTH] <= bmem_rdata;
         col_cnt_q <= col_cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter: randomized line traffic against a cycle-level memory/cache model of the adapter.
module tb_bmem_line_adapter;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  ic_addr, dc_addr, bmem_addr, bmem_raddr;
   logic         ic_read, ic_resp, dc_read, dc_write, dc_resp;
   logic [255:0] ic_rdata, dc_rdata, dc_wdata;
   logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid, err;
   logic [63:0]  bmem_wdata, bmem_rdata;

   int n_chk = 0, n_err = 0, ic_pulses = 0, dc_pulses = 0, both_hi = 0, wr_n = 0;
   logic [255:0] wr_line = '0;

   bmem_line_adapter dut (
      .clk(clk), .rst(rst),
      .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
      .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
      .dc_rdata(dc_rdata), .dc_resp(dc_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
   );

   always #5 clk = ~clk;

   // Memory-side observer: what the memory would store from accepted write beats.
   always @(negedge clk) begin
      if (ic_resp) ic_pulses++;
      if (dc_resp) dc_pulses++;
      if (bmem_read && bmem_write) both_hi++;
      if (bmem_ready && bmem_write) begin
         wr_line[63:0] = bmem_wdata;
         wr_n = 1;
      end else if (bmem_ready && wr_n > 0 && wr_n < 4) begin
         wr_line[64*wr_n +: 64] = bmem_wdata;
         wr_n++;
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle_inputs;
      ic_addr = '0; ic_read = 0; dc_addr = '0; dc_read = 0; dc_write = 0; dc_wdata = '0;
      bmem_ready = 1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      idle_inputs();
      tick();
      tick();
      rst = 0;
      tick();
   endtask

   task automatic send_burst(input logic [31:0] a, input logic [255:0] l, input int n);
      for (int j = 0; j < n; j++) begin
         bmem_rvalid = 1;
         bmem_raddr = a;
         bmem_rdata = l[64*j +: 64];
         tick();
      end
      bmem_rvalid = 0;
      bmem_raddr = '0;
      bmem_rdata = '0;
   endtask

   task automatic do_read(input logic is_dc, input logic [31:0] a, input logic [255:0] l,
                          input int stall, input int gap);
      logic [31:0] la;
      la = a & ~32'h1f;
      if (is_dc) begin dc_addr = a; dc_read = 1; end
      else begin ic_addr = a; ic_read = 1; end
      tick();
      chk("rd_strobe", {bmem_read, bmem_write}, 2'b10);
      chk("rd_addr", bmem_addr, la);
      for (int s = 0; s < stall; s++) begin
         bmem_ready = 0;
         tick();
         chk("rd_hold", {bmem_read, bmem_addr}, {1'b1, la});
      end
      bmem_ready = 1;
      tick();
      chk("rd_accepted", bmem_read, 0);
      repeat (gap) tick();
      send_burst(la, l, 4);
      chk("rd_resp", {ic_resp, dc_resp}, is_dc ? 2'b01 : 2'b10);
      chk("rd_line", is_dc ? dc_rdata : ic_rdata, l);
      ic_read = 0;
      dc_read = 0;
      tick();
      chk("rd_resp_pulse", {ic_resp, dc_resp}, 2'b00);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [255:0] l, input int sb, input int sl);
      int b = 0, s = 0, c = 1;
      dc_addr = a; dc_wdata = l; dc_write = 1;
      tick();
      chk("wr_addr", bmem_addr, a & ~32'h1f);
      while (b < 4 && c < 40) begin
         bmem_ready = !(b == sb && s < sl);
         chk("wr_beat", bmem_wdata, l[64*b +: 64]);
         chk("wr_strobe", {bmem_write, bmem_read}, {b == 0, 1'b0});
         if (bmem_ready) b++;
         else s++;
         tick();
         c++;
      end
      bmem_ready = 1;
      chk("wr_resp", dc_resp, 1);
      chk("wr_resp_cycle", c, 5 + sl);
      chk("wr_mem_line", wr_line, l);
      dc_write = 0;
      tick();
      chk("wr_resp_pulse", dc_resp, 0);
   endtask

   initial begin
      logic [255:0] l1, l2, l3;
      int seen, p0;
      rst = 1;
      idle_inputs();
      #1;
      chk("rst_strobes", {bmem_read, bmem_write, ic_resp, dc_resp, err}, 5'b0);
      chk("rst_addr", bmem_addr, 0);
      chk("rst_wdata", bmem_wdata, 0);
      chk("rst_ic_rdata", ic_rdata, 0);
      chk("rst_dc_rdata", dc_rdata, 0);
      tick();
      rst = 0;
      tick();

      do_read(0, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0);
      do_write(32'h80, rnd_line(), 2, 2);
      do_write(32'h80, rnd_line(), 4, 0);

      // Simultaneous requests from reset: dcache wins, memory answers icache first.
      do_reset();
      l1 = rnd_line(); l2 = rnd_line();
      dc_addr = 32'h100; dc_read = 1; ic_addr = 32'h200; ic_read = 1;
      tick();
      chk("rr_first", {bmem_read, bmem_addr}, {1'b1, 32'h100});
      tick();
      chk("rr_gap", bmem_read, 0);
      tick();
      chk("rr_second", {bmem_read, bmem_addr}, {1'b1, 32'h200});
      tick();
      send_burst(32'h200, l2, 4);
      chk("ooo_ic_resp", {ic_resp, dc_resp}, 2'b10);
      chk("ooo_ic_line", ic_rdata, l2);
      ic_read = 0;
      send_burst(32'h100, l1, 4);
      chk("ooo_dc_resp", {ic_resp, dc_resp}, 2'b01);
      chk("ooo_dc_line", dc_rdata, l1);
      chk("ooo_ic_held", ic_rdata, l2);
      dc_read = 0;
      tick();

      // Same-line conflict: dcache read of a line icache awaits.
      l1 = rnd_line(); l2 = rnd_line();
      ic_addr = 32'h40; ic_read = 1;
      tick();
      chk("cf_ic_issue", {bmem_read, bmem_addr}, {1'b1, 32'h40});
      tick();
      dc_addr = 32'h44; dc_read = 1;
      seen = 0;
      repeat (4) begin
         tick();
         if (bmem_read) seen++;
      end
      chk("cf_blocked", seen, 0);
      send_burst(32'h40, l1, 4);
      chk("cf_ic_resp", {ic_resp, ic_rdata}, {1'b1, l1});
      chk("cf_still_blocked", bmem_read, 0);
      ic_read = 0;
      tick();
      chk("cf_dc_issue", {bmem_read, bmem_addr}, {1'b1, 32'h40});
      tick();
      send_burst(32'h40, l2, 4);
      chk("cf_dc_resp", {dc_resp, dc_rdata}, {1'b1, l2});
      dc_read = 0;
      tick();

      // Protocol errors.
      do_reset();
      p0 = ic_pulses + dc_pulses;
      bmem_rvalid = 1; bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'h1;
      tick();
      bmem_rvalid = 0;
      chk("err_nomatch", err, 1);
      repeat (3) tick();
      chk("err_sticky", err, 1);
      chk("err_no_resp", ic_pulses + dc_pulses, p0);
      do_reset();
      chk("err_cleared", err, 0);
      p0 = ic_pulses;
      ic_addr = 32'h3000; ic_read = 1;
      tick();
      tick();
      send_burst(32'h3000, rnd_line(), 2);
      repeat (4) tick();
      chk("err_rvalid_drop", err, 1);
      chk("err_drop_no_resp", ic_pulses, p0);
      ic_read = 0;
      do_reset();
      p0 = dc_pulses;
      dc_addr = 32'h7000; dc_read = 1;
      tick();
      tick();
      l1 = rnd_line();
      bmem_rvalid = 1;
      for (int j = 0; j < 4; j++) begin
         bmem_raddr = (j == 0) ? 32'h7000 : 32'h7100;
         bmem_rdata = l1[64*j +: 64];
         tick();
      end
      bmem_rvalid = 0;
      tick();
      chk("err_raddr_change", err, 1);
      chk("err_change_no_resp", dc_pulses, p0);
      dc_read = 0;

      // Asynchronous reset in the middle of a write burst.
      do_reset();
      l1 = rnd_line();
      dc_addr = 32'h500; dc_wdata = l1; dc_write = 1;
      tick();
      tick();
      tick();
      chk("rst_mid_beat2", bmem_wdata, l1[128 +: 64]);
      #2 rst = 1;
      #1;
      chk("rst_mid_outs", {bmem_read, bmem_write, bmem_addr, bmem_wdata, ic_resp, dc_resp, err}, '0);
      chk("rst_mid_rdata", dc_rdata, 0);
      p0 = dc_pulses;
      dc_write = 0;
      tick();
      rst = 0;
      tick();
      tick();
      chk("rst_mid_no_resp", dc_pulses, p0);
      do_write(32'h500, rnd_line(), 4, 0);
      do_read(1, 32'h540, rnd_line(), 1, 1);

      for (int i = 0; i < 12; i++) begin
         int p;
         p = $urandom_range(0, 2);
         if (p == 2) do_write($urandom, rnd_line(), $urandom_range(0, 3), $urandom_range(0, 3));
         else do_read(p[0], $urandom, rnd_line(), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      chk("never_both_strobes", both_hi, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
